ra_pq_p: RTL

- Parametrised register-array priority queue; successor to the reduced register-array PQ.
- Accepts one operation every cycle. There is no odd/even phase alternation and no busy stall.
- Holds DEPTH key/value entries in a fully sorted shift-register array. The head entry is always presented on kvo.
- Adds selectable min/max ordering, FIFO ordering among equal keys, full/count status, replace (enq+deq in one cycle) and error flags.

---
 rtl/pq_pkg.sv | 24 ++
 rtl/ra_pq_p_cell.sv | 89 ++++++++
 rtl/ra_pq_p.sv | 108 ++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared key/value types, operation codes and ordering predicate for the PQ variants
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_REP  = 2'd3
  } pq_op_e;

  // Strict, unsigned: equal keys are never better, which keeps arrival order.
  function automatic logic better(input kv_t a, input kv_t b, input logic max_first);
    return max_first ? (a.key > b.key) : (a.key < b.key);
  endfunction

endpackage

// File: rtl/ra_pq_p_cell.sv
// rtl/ra_pq_p_cell.sv - one slot of the sorted shift-register array; decides its next state from its neighbours
module ra_pq_p_cell
  import pq_pkg::*;
#(
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
  parameter int MAX_FIRST = 0,
  parameter int IS_FIRST  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     op,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
  input  logic                           prev_v,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] prev_kv,
  input  logic                           prev_ins,
  input  logic                           next_v,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] next_kv,
  output logic                           v,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] kv,
  output logic                           ins
);

  localparam int KVW = KEY_WIDTH + VAL_WIDTH;

  logic           ge_self;
  logic           ge_next;
  logic           v_d;
  logic [KVW-1:0] kv_d;

  // Keys are zero-extended into the shared struct so the common predicate applies.
  function automatic logic behind(input logic [KVW-1:0] a, input logic [KVW-1:0] e);
    kv_t ea;
    kv_t eb;
    ea = '0;
    eb = '0;
    ea.key[KEY_WIDTH-1:0] = a[KVW-1 -: KEY_WIDTH];
    eb.key[KEY_WIDTH-1:0] = e[KVW-1 -: KEY_WIDTH];
    return !better(ea, eb, MAX_FIRST != 0);
  endfunction

  assign ge_self = v && behind(kvi, kv);
  assign ge_next = next_v && behind(kvi, next_kv);
  assign ins     = !ge_self;

  always_comb begin
    v_d  = v;
    kv_d = kv;
    unique case (op)
      OP_ENQ: begin
        if (ins) begin
          if (prev_ins) begin
            v_d  = prev_v;
            kv_d = prev_kv;
          end else begin
            v_d  = 1'b1;
            kv_d = kvi;
          end
        end
      end
      OP_DEQ: begin
        v_d  = next_v;
        kv_d = next_kv;
      end
      OP_REP: begin
        // Head leaves: cells up to the insertion slot pull from behind, the slot takes kvi.
        if (ge_next) begin
          v_d  = next_v;
          kv_d = next_kv;
        end else if ((IS_FIRST != 0) || ge_self) begin
          v_d  = 1'b1;
          kv_d = kvi;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v  <= 1'b0;
      kv <= '0;
    end else begin
      v  <= v_d;
      kv <= kv_d;
    end
  end

endmodule

// File: rtl/ra_pq_p.sv
// rtl/ra_pq_p.sv - single-cycle register-array priority queue with min/max ordering, replace and error flag
module ra_pq_p
  import pq_pkg::*;
#(
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
  parameter int DEPTH     = 8,
  parameter int MAX_FIRST = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enq,
  input  logic                           deq,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
  output logic                           ovalid,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           err
);

  localparam int KVW = KEY_WIDTH + VAL_WIDTH;
  localparam int CW  = $clog2(DEPTH+1);

  logic [1:0]       op;
  logic [DEPTH-1:0] v_a;
  logic [DEPTH-1:0] ins_a;
  logic [KVW-1:0]   kv_a [DEPTH];

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign ovalid = !empty;
  assign kvo    = kv_a[0];

  // enq+deq on an empty queue degrades to a plain enqueue.
  always_comb begin
    op = OP_HOLD;
    if (enq && deq) begin
      op = empty ? OP_ENQ : OP_REP;
    end else if (enq) begin
      op = full ? OP_HOLD : OP_ENQ;
    end else if (deq) begin
      op = empty ? OP_HOLD : OP_DEQ;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic           pv;
    logic           pins;
    logic [KVW-1:0] pkv;
    logic           nv;
    logic [KVW-1:0] nkv;

    if (i == 0) begin : g_head
      assign pv   = 1'b0;
      assign pins = 1'b0;
      assign pkv  = '0;
    end else begin : g_body
      assign pv   = v_a[i-1];
      assign pins = ins_a[i-1];
      assign pkv  = kv_a[i-1];
    end

    if (i == DEPTH-1) begin : g_tail
      assign nv  = 1'b0;
      assign nkv = '0;
    end else begin : g_link
      assign nv  = v_a[i+1];
      assign nkv = kv_a[i+1];
    end

    ra_pq_p_cell #(
      .KEY_WIDTH (KEY_WIDTH),
      .VAL_WIDTH (VAL_WIDTH),
      .MAX_FIRST (MAX_FIRST),
      .IS_FIRST  ((i == 0) ? 1 : 0)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .op       (op),
      .kvi      (kvi),
      .prev_v   (pv),
      .prev_kv  (pkv),
      .prev_ins (pins),
      .next_v   (nv),
      .next_kv  (nkv),
      .v        (v_a[i]),
      .kv       (kv_a[i]),
      .ins      (ins_a[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      err <= (enq && !deq && full) || (deq && empty);
      if (op == OP_ENQ) begin
        count <= count + CW'(1);
      end else if (op == OP_DEQ) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
